uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL provide parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL provide parameter BIT_RATE, default 9600, serial bit rate in bits/s.
REQ-003 The block SHALL provide parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 The block SHALL provide parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 The block SHALL derive CYCLES_PER_BIT = CLK_HZ / BIT_RATE (integer division, truncated), and configurations with CYCLES_PER_BIT < 2 are unsupported.
REQ-006 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-007 The block SHALL have port resetn, input, 1, reset: asynchronous, active-low.
REQ-008 The block SHALL have port uart_txd, output, 1, serial transmit line; idle high.
REQ-009 The block SHALL have port uart_tx_busy, output, 1, high while a frame is in progress.
REQ-010 The block SHALL have port uart_tx_en, input, 1, transmit request, sampled each rising edge.
REQ-011 The block SHALL have port uart_tx_data, input, PAYLOAD_BITS, data to send.

Function
REQ-012 The block SHALL implement FSM states IDLE, START, SEND, STOP.
REQ-013 The block SHALL accept a request in IDLE when uart_tx_en=1 at a rising edge, capture uart_tx_data into an internal shift register on that edge, and enter START.
REQ-014 The block SHALL ignore uart_tx_en in START, SEND and STOP: no queueing, no frame restart, captured data unchanged.
REQ-015 The block SHALL ignore changes on uart_tx_data after capture.
REQ-016 The block SHALL drive uart_txd from a register: START=0, SEND=current shift-register LSB, IDLE/STOP=1; no combinational glitches.
REQ-017 uart_tx_busy SHALL be high in START, SEND and STOP, rising the cycle after acceptance and low in IDLE.
REQ-018 A bit-period counter SHALL count 0..CYCLES_PER_BIT-1, with each bit (start, data, stop) held for exactly CYCLES_PER_BIT cycles.
REQ-019 Data bits SHALL be sent LSB first, with a bit counter counting 0..PAYLOAD_BITS-1 in SEND.
REQ-020 Transitions SHALL occur at bit-period end: START->SEND; SEND->SEND (shift, next bit) until the last data bit, then SEND->STOP; STOP->IDLE after STOP_BITS periods.
REQ-021 Frame duration (busy high) SHALL be exactly (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles.
REQ-022 A request SHALL be accepted on the first edge in IDLE, i.e. the same edge busy is first seen low, giving back-to-back frames with no idle gap beyond one cycle.
REQ-023 Counters SHALL be sized clog2 of their maximum value +1, and no counter SHALL wrap past its terminal value.
REQ-024 uart_tx_en held high continuously SHALL produce back-to-back frames, each using data sampled at its own acceptance edge.

Reset
REQ-025 When resetn=0 the block SHALL immediately, asynchronously, set uart_txd=1, uart_tx_busy=0, FSM=IDLE, and clear all counters and the shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame, with the line high at once and no residual bits after release.
REQ-027 After resetn release, the first rising edge SHALL be able to accept a request.

Verification
REQ-028 The bench SHALL cover these directed scenarios, all with CLK_HZ=1000000, BIT_RATE=100000 (CYCLES_PER_BIT=10), PAYLOAD_BITS=8, STOP_BITS=1:
- Single 0xA5 request -> txd sequence 0,1,0,1,0,0,1,0,1,1, each 10 cycles; busy high 100 cycles.
- Data 0x00 then 0xFF, uart_tx_en pulsed on the first idle cycle after each -> two frames, data bits all 0 / all 1, at most 1 idle cycle between.
- uart_tx_en pulsed at cycle 35 of a 0x3C frame with data 0x81 -> ignored; only 0x3C transmitted, busy low after cycle 100.
- uart_tx_data changed 0x55->0xAA at cycle 5 after accepting 0x55 -> 0x55 transmitted.
- resetn low at cycle 47 of a frame -> txd=1 and busy=0 asynchronously; after release, a 0x12 request yields a clean 0x12 frame.
- STOP_BITS=2, data 0x0F -> stop level high 20 cycles; busy high 110 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits sent LSB first, and STOP_BITS stop bits.
// Each bit is held for CLK_HZ/BIT_RATE clock cycles. The serial line comes straight from a flop.
module uart_tx #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CYC_W   = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_MAX = ((PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS) - 1;
  localparam int BIT_W   = (BIT_MAX > 0) ? $clog2(BIT_MAX + 1) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, STOP} state_t;

  state_t                  state_q, state_d;
  logic [CYC_W-1:0]        cyc_cnt_q, cyc_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    bit_end;

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bit_end   = (cyc_cnt_q == CYC_LAST);

    if (state_q != IDLE) begin
      cyc_cnt_d = bit_end ? '0 : cyc_cnt_q + 1'b1;
    end

    // The bit counter indexes data bits in SEND and is reused to count stop bits in STOP.
    case (state_q)
      IDLE: begin
        if (uart_tx_en) begin
          state_d   = START;
          shift_d   = uart_tx_data;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) state_d = SEND;
      end
      SEND: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state, so the flop output lines up with the state.
    case (state_d)
      START:   txd_d = 1'b0;
      SEND:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 cycles per bit. One instance has one stop bit, the other has two.
// Both instances share the same inputs. The bench samples outputs on the falling edge.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       txd1, busy1, txd2, busy2;

  int checks = 0;
  int errors = 0;

  logic txd_log  [0:127];
  logic busy_log [0:127];

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .resetn(resetn), .uart_txd(txd1), .uart_tx_busy(busy1),
    .uart_tx_en(tx_en), .uart_tx_data(tx_data)
  );

  uart_tx #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .uart_txd(txd2), .uart_tx_busy(busy2),
    .uart_tx_en(tx_en), .uart_tx_data(tx_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge. The request is accepted at the next rising edge.
  // The task returns on the falling edge of frame cycle 0.
  task automatic start_frame(input logic [7:0] d);
    tx_data = d;
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en   = 1'b0;
  endtask

  task automatic capture(input int sel, input int len, input int inj_cyc,
                         input logic inj_en, input logic [7:0] inj_data);
    for (int i = 0; i < len; i++) begin
      if (i == inj_cyc) begin
        tx_data = inj_data;
        tx_en   = inj_en;
      end else if (i == inj_cyc + 1) begin
        tx_en = 1'b0;
      end
      txd_log[i]  = (sel == 1) ? txd2 : txd1;
      busy_log[i] = (sel == 1) ? busy2 : busy1;
      @(negedge clk);
    end
  endtask

  // exp_bits[0] is the start bit, followed by the data bits LSB first, followed by the stop bits.
  task automatic check_frame(input string tag, input int sel, input logic [10:0] exp_bits,
                             input int nbits, input int len);
    logic [9:0] v;
    int         cnt;
    for (int k = 0; k < nbits; k++) begin
      for (int j = 0; j < CPB; j++) v[j] = txd_log[k*CPB + j];
      chk($sformatf("%s_bit%0d", tag, k), 32'(v), exp_bits[k] ? 32'h3FF : 32'h0);
    end
    cnt = 0;
    for (int i = 0; i < len; i++) if (busy_log[i]) cnt++;
    chk($sformatf("%s_busy_cycles", tag), 32'(cnt), 32'(len));
    chk($sformatf("%s_busy_end", tag), 32'((sel == 1) ? busy2 : busy1), 32'h0);
  endtask

  initial begin
    int idle_hi;
    int idle_busy;

    resetn  = 1'b0;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd1", 32'(txd1), 32'h1);
    chk("rst_busy1", 32'(busy1), 32'h0);
    chk("rst_txd2", 32'(txd2), 32'h1);
    chk("rst_busy2", 32'(busy2), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame: the line should read 0,1,0,1,0,0,1,0,1,1.
    start_frame(8'hA5);
    capture(0, 100, -1, 1'b0, 8'h00);
    check_frame("a5", 0, {2'b11, 8'hA5, 1'b0}, 10, 100);

    // Back-to-back 0x00 then 0xFF, with the second request issued on the first idle cycle.
    start_frame(8'h00);
    capture(0, 100, -1, 1'b0, 8'h00);
    check_frame("x00", 0, {2'b11, 8'h00, 1'b0}, 10, 100);
    start_frame(8'hFF);
    capture(0, 100, -1, 1'b0, 8'h00);
    check_frame("xff", 0, {2'b11, 8'hFF, 1'b0}, 10, 100);

    // A request at cycle 35 of a 0x3C frame is ignored, and no frame follows afterwards.
    start_frame(8'h3C);
    capture(0, 100, 35, 1'b1, 8'h81);
    check_frame("x3c", 0, {2'b11, 8'h3C, 1'b0}, 10, 100);
    capture(0, 15, -1, 1'b0, 8'h00);
    idle_hi   = 0;
    idle_busy = 0;
    for (int i = 0; i < 15; i++) begin
      if (txd_log[i]) idle_hi++;
      if (busy_log[i]) idle_busy++;
    end
    chk("x3c_after_txd_high", 32'(idle_hi), 32'd15);
    chk("x3c_after_busy", 32'(idle_busy), 32'd0);

    // Data changes after acceptance do not affect the frame.
    start_frame(8'h55);
    capture(0, 100, 5, 1'b0, 8'hAA);
    check_frame("x55", 0, {2'b11, 8'h55, 1'b0}, 10, 100);

    // Reset at cycle 47, while data bit 3 of 0x00 is being sent.
    start_frame(8'h00);
    capture(0, 47, -1, 1'b0, 8'h00);
    chk("pre_rst_txd", 32'(txd1), 32'h0);
    chk("pre_rst_busy", 32'(busy1), 32'h1);
    resetn = 1'b0;
    #1;
    chk("async_rst_txd", 32'(txd1), 32'h1);
    chk("async_rst_busy", 32'(busy1), 32'h0);
    chk("async_rst_busy2", 32'(busy2), 32'h0);
    repeat (2) @(negedge clk);
    chk("hold_rst_txd", 32'(txd1), 32'h1);
    resetn = 1'b1;
    start_frame(8'h12);
    capture(0, 100, -1, 1'b0, 8'h00);
    check_frame("x12", 0, {2'b11, 8'h12, 1'b0}, 10, 100);

    // Two stop bits: the stop level stays high for 20 cycles and busy lasts 110 cycles.
    repeat (20) @(negedge clk);
    start_frame(8'h0F);
    capture(1, 110, -1, 1'b0, 8'h00);
    check_frame("stop2", 1, {2'b11, 8'h0F, 1'b0}, 11, 110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
